hs_tx_arbiter: RTL and testbench

HS_TX_ARBITER -- requirements
Module: hs_tx_arbiter

---
 rtl/hs_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_hs_tx_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_tx_arbiter.sv
// hs_tx_arbiter: four-source round-robin arbiter driving a four-phase req/ack
// handshake into an asynchronous clock domain, with transfer timeout and idle gap.
module hs_tx_arbiter #(
    parameter int DW         = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic            i_clk_a,
    input  logic            i_rst_n,
    input  logic [3:0]      i_src_valid,
    input  logic [4*DW-1:0] i_src_data,
    output logic [3:0]      o_src_done,
    input  logic            i_data_ack,
    output logic [DW-1:0]   o_data,
    output logic            o_data_req,
    output logic [1:0]      o_grant_id,
    output logic            o_busy,
    output logic            o_timeout
);

    // state    | meaning
    // IDLE     | waiting for any valid source
    // REQ      | o_data_req high, waiting for synchronised ack or timeout
    // WAIT_LOW | req dropped, waiting for ack to return low
    // GAP      | enforced idle cycles before the next arbitration
    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW, GAP} state_t;

    localparam logic [10:0] TMO_LIM  = 11'(TIMEOUT);
    localparam logic [7:0]  GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t          state, state_nxt;
    logic            ack_m, ack_s;
    logic [1:0]      last_grant, last_grant_nxt;
    logic [9:0]      tmo_cnt, tmo_cnt_nxt;
    logic [7:0]      gap_cnt, gap_cnt_nxt;
    logic [DW-1:0]   data_nxt;
    logic            req_nxt;
    logic [1:0]      grant_nxt;
    logic [3:0]      done_nxt;
    logic            timeout_nxt;
    logic            win_found;
    logic [1:0]      win_id;
    logic [1:0]      cand;
    logic            tmo_hit;

    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= i_data_ack;
            ack_s <= ack_m;
        end
    end

    // Search starts one past the last successful grant.
    always_comb begin
        win_found = 1'b0;
        win_id    = last_grant;
        cand      = last_grant;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!win_found && i_src_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign tmo_hit = ({1'b0, tmo_cnt} + 11'd1) >= TMO_LIM;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        tmo_cnt_nxt    = tmo_cnt;
        gap_cnt_nxt    = gap_cnt;
        data_nxt       = o_data;
        req_nxt        = o_data_req;
        grant_nxt      = o_grant_id;
        done_nxt       = 4'b0000;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    data_nxt    = i_src_data[win_id*DW +: DW];
                    grant_nxt   = win_id;
                    req_nxt     = 1'b1;
                    tmo_cnt_nxt = 10'd0;
                    state_nxt   = REQ;
                end
            end
            REQ: begin
                // A late ack on the timeout cycle still counts as success.
                if (ack_s) begin
                    req_nxt              = 1'b0;
                    done_nxt[o_grant_id] = 1'b1;
                    last_grant_nxt       = o_grant_id;
                    state_nxt            = WAIT_LOW;
                end else if (tmo_hit) begin
                    req_nxt     = 1'b0;
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_LOW;
                end else if (tmo_cnt != 10'h3FF) begin
                    tmo_cnt_nxt = tmo_cnt + 10'd1;
                end
            end
            WAIT_LOW: begin
                if (!ack_s) begin
                    if (GAP_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_cnt_nxt = GAP_LOAD;
                        state_nxt   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_a or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            tmo_cnt    <= 10'd0;
            gap_cnt    <= 8'd0;
            o_data     <= '0;
            o_data_req <= 1'b0;
            o_grant_id <= 2'd0;
            o_src_done <= 4'b0000;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            o_data     <= data_nxt;
            o_data_req <= req_nxt;
            o_grant_id <= grant_nxt;
            o_src_done <= done_nxt;
            o_timeout  <= timeout_nxt;
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_hs_tx_arbiter.sv
// Bench for hs_tx_arbiter: plays the domain-B responder and checks grants,
// handshake timing, timeouts and gaps against a transaction-level model.
module tb_hs_tx_arbiter;

    localparam int DW  = 4;
    localparam int GAP = 4;
    localparam int TMO = 8;
    localparam int RT  = 3;   // ack edge -> two sync flops -> FSM reaction edge

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      src_valid;
    logic [4*DW-1:0] src_data;
    logic [3:0]      src_done;
    logic            data_ack;
    logic [DW-1:0]   data;
    logic            data_req;
    logic [1:0]      grant_id;
    logic            busy;
    logic            timeout;

    logic [3:0]      z_valid;
    logic [4*DW-1:0] z_sdata;
    logic [3:0]      z_done;
    logic            z_ack;
    logic [DW-1:0]   z_data;
    logic            z_req;
    logic [1:0]      z_gid;
    logic            z_busy;
    logic            z_tmo;

    int              vectors = 0;
    int              errors  = 0;
    logic [DW-1:0]   model_data [4];
    logic [1:0]      model_last;
    logic [3:0]      acc_done_v;
    int              acc_done_n;
    int              acc_tmo_n;

    always #5 clk = ~clk;

    hs_tx_arbiter #(.DW(DW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) u_dut (
        .i_clk_a(clk), .i_rst_n(rst_n), .i_src_valid(src_valid), .i_src_data(src_data),
        .o_src_done(src_done), .i_data_ack(data_ack), .o_data(data), .o_data_req(data_req),
        .o_grant_id(grant_id), .o_busy(busy), .o_timeout(timeout)
    );

    hs_tx_arbiter #(.DW(DW), .GAP_CYCLES(0), .TIMEOUT(TMO)) u_dut_gap0 (
        .i_clk_a(clk), .i_rst_n(rst_n), .i_src_valid(z_valid), .i_src_data(z_sdata),
        .o_src_done(z_done), .i_data_ack(z_ack), .o_data(z_data), .o_data_req(z_req),
        .o_grant_id(z_gid), .o_busy(z_busy), .o_timeout(z_tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_grant(input logic [3:0] v, input logic [1:0] last);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (int'(last) + k) % 4;
            if (v[idx]) return 2'(idx);
        end
        return last;
    endfunction

    task automatic set_data();
        for (int k = 0; k < 4; k++) begin
            model_data[k] = DW'($urandom);
            src_data[k*DW +: DW] = model_data[k];
        end
    endtask

    task automatic step();
        @(negedge clk);
        acc_done_v = acc_done_v | src_done;
        if (src_done != 4'b0000) acc_done_n++;
        if (timeout === 1'b1) acc_tmo_n++;
    endtask

    // One complete transaction; lat < 0 means domain B never acks.
    task automatic serve(input string tag, input int lat, input int hold, input bit kill_valid);
        logic [1:0]    eg;
        logic [DW-1:0] ed;
        bit            success, acked, acked_exp, ok_stable, ok_held;
        int            t, req_cyc, req_exp, gap;
        eg        = exp_grant(src_valid, model_last);
        ed        = model_data[eg];
        success   = (lat >= 0) && (lat + RT <= TMO);
        req_exp   = success ? lat + RT : TMO;
        acked_exp = (lat >= 0) && (lat < req_exp);
        t = 0;
        while (data_req !== 1'b1 && t < 50) begin step(); t++; end
        chk({tag, "/req_rise"}, data_req, 1'b1);
        chk({tag, "/grant_latency"}, t, 1);
        chk({tag, "/grant_id"}, grant_id, eg);
        src_data = (4*DW)'($urandom);
        if (kill_valid) src_valid = 4'b0000;
        acc_done_v = 4'b0000; acc_done_n = 0; acc_tmo_n = 0;
        ok_stable = 1'b1; ok_held = 1'b1; acked = 1'b0; req_cyc = 0; t = 0;
        while (data_req === 1'b1 && t < 2000) begin
            req_cyc++;
            if (data !== ed || grant_id !== eg) ok_stable = 1'b0;
            if (t == lat) begin data_ack = 1'b1; acked = 1'b1; end
            step(); t++;
        end
        if (acked) begin
            for (int h = 0; h < hold; h++) begin
                if (data_req !== 1'b0 || busy !== 1'b1) ok_held = 1'b0;
                if (data !== ed || grant_id !== eg) ok_stable = 1'b0;
                step();
            end
        end
        data_ack = 1'b0;
        gap = 0;
        while (busy === 1'b1 && gap < 2000) begin
            if (data_req !== 1'b0) ok_held = 1'b0;
            if (data !== ed || grant_id !== eg) ok_stable = 1'b0;
            step(); gap++;
        end
        chk({tag, "/req_cycles"}, req_cyc, req_exp);
        chk({tag, "/done_vec"}, acc_done_v, success ? (4'b0001 << eg) : 4'b0000);
        chk({tag, "/done_count"}, acc_done_n, success ? 1 : 0);
        chk({tag, "/timeout_count"}, acc_tmo_n, success ? 0 : 1);
        chk({tag, "/data_stable"}, ok_stable, 1'b1);
        chk({tag, "/req_low_while_ack"}, ok_held, 1'b1);
        chk({tag, "/gap_cycles"}, gap, acked_exp ? GAP + RT : GAP + 1);
        if (success) model_last = eg;
        set_data();
    endtask

    initial begin
        int t, lat;
        src_valid = 4'b0000; src_data = '0; data_ack = 1'b0;
        z_valid = 4'b0000; z_sdata = '0; z_ack = 1'b0;
        acc_done_v = 4'b0000; acc_done_n = 0; acc_tmo_n = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset/req", data_req, 1'b0);
        chk("reset/busy", busy, 1'b0);
        chk("reset/data", data, '0);
        chk("reset/grant_id", grant_id, 2'd0);
        chk("reset/done", src_done, 4'b0000);
        chk("reset/timeout", timeout, 1'b0);
        rst_n = 1'b1;
        model_last = 2'd3;
        set_data();

        src_valid = 4'b1111;
        for (int r = 0; r < 5; r++)
            serve($sformatf("rr%0d", r), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 1'b0);
        src_valid = 4'b0000;

        src_valid = 4'b0001;
        model_data[0] = 4'hA;
        src_data[DW-1:0] = 4'hA;
        serve("single", 3, 0, 1'b0);
        src_valid = 4'b0000;

        src_valid = 4'b0100;
        serve("late_ack", 1, 20, 1'b0);
        src_valid = 4'b0000;

        src_valid = 4'b0010;
        serve("tmo", -1, 0, 1'b0);
        serve("tmo_regrant", 2, 0, 1'b0);
        src_valid = 4'b0000;

        src_valid = 4'b1000;
        serve("ack_on_tmo_edge", 5, 0, 1'b0);
        serve("ack_after_tmo", 6, 3, 1'b0);
        serve("after_tmo_regrant", 0, 0, 1'b0);
        src_valid = 4'b0000;

        src_valid = 4'b0001;
        serve("valid_dropped", 2, 0, 1'b1);

        for (int r = 0; r < 16; r++) begin
            src_valid = 4'($urandom_range(1, 15));
            lat = int'($urandom_range(0, 7));
            if (lat == 7) lat = -1;
            serve($sformatf("rand%0d", r), lat, int'($urandom_range(0, 3)), 1'b0);
        end
        src_valid = 4'b0000;

        src_valid = 4'b0100;
        t = 0;
        while (data_req !== 1'b1 && t < 50) begin step(); t++; end
        chk("rst_mid/grant_id", grant_id, 2'd2);
        chk("rst_mid/data", data, model_data[2]);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid/req_async", data_req, 1'b0);
        chk("rst_mid/data_async", data, '0);
        chk("rst_mid/busy_async", busy, 1'b0);
        chk("rst_mid/done_async", src_done, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 2'd3;
        src_valid = 4'b1111;
        serve("post_rst", 2, 0, 1'b0);
        src_valid = 4'b0000;

        z_sdata = 16'h123C;
        z_valid = 4'b0011;
        t = 0;
        while (z_req !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        chk("gap0/first_gid", z_gid, 2'd0);
        chk("gap0/first_data", z_data, 4'hC);
        z_ack = 1'b1;
        t = 0;
        while (z_req !== 1'b0 && t < 50) begin @(negedge clk); t++; end
        chk("gap0/req_drop", z_req, 1'b0);
        chk("gap0/done", z_done, 4'b0001);
        z_ack = 1'b0;
        t = 0;
        while (z_req !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        chk("gap0/rerise_cycles", t, 4);
        chk("gap0/second_gid", z_gid, 2'd1);
        chk("gap0/second_data", z_data, 4'h3);
        z_valid = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
